// File: rtl/logs_envelope_dac.sv
// rtl/logs_envelope_dac.sv - ADSR envelope over oscillator popcount, first-order sigma-delta output
module logs_envelope_dac #(
    parameter int N        = 4,
    parameter int ENV_BITS = 8,
    parameter int TICK_DIV = 4096,
    parameter int SUSTAIN  = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        audio_in,
    input  logic                gate,
    output logic                audio_out,
    output logic [ENV_BITS-1:0] env_out,
    output logic                active
);

    localparam int K  = $clog2(N + 1);
    localparam int E  = ENV_BITS;
    localparam int W  = K + E;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [E-1:0]  ENV_MAX  = {E{1'b1}};
    localparam logic [E-1:0]  ENV_SUS  = E'(SUSTAIN);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  FULL     = W'(N) << E;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [E-1:0]  env_q, env_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [K-1:0]  sum_q, sum_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          audio_q, audio_d;
    logic          tick;
    logic [W-1:0]  sample;
    logic [W:0]    s;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + K'(audio_in[i]);
        end
    end

    assign tick    = (presc_q == PRE_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    // Gate events take priority: a transition cycle never also steps env.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            S_IDLE: begin
                env_d = '0;
                if (gate) state_d = S_ATTACK;
            end
            S_ATTACK: begin
                if (!gate)                 state_d = S_RELEASE;
                else if (env_q == ENV_MAX) state_d = S_DECAY;
                else if (tick)             env_d   = env_q + E'(1);
            end
            S_DECAY: begin
                if (!gate)                  state_d = S_RELEASE;
                else if (env_q <= ENV_SUS)  state_d = S_SUSTAIN;
                else if (tick)              env_d   = env_q - E'(1);
            end
            S_SUSTAIN: begin
                if (!gate) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (gate)              state_d = S_ATTACK;
                else if (env_q == '0)  state_d = S_IDLE;
                else if (tick)         env_d   = env_q - E'(1);
            end
            default: begin
                state_d = S_IDLE;
                env_d   = '0;
            end
        endcase
    end

    // sample never reaches FULL, so acc stays below FULL and one subtraction suffices.
    assign sample = W'(sum_q) * W'(env_q);
    assign s      = {1'b0, acc_q} + {1'b0, sample};

    always_comb begin
        audio_d = 1'b0;
        acc_d   = s[W-1:0];
        if (s >= {1'b0, FULL}) begin
            audio_d = 1'b1;
            acc_d   = W'(s - {1'b0, FULL});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            env_q   <= '0;
            presc_q <= '0;
            sum_q   <= '0;
            acc_q   <= '0;
            audio_q <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            presc_q <= presc_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            audio_q <= audio_d;
        end
    end

    assign audio_out = audio_q;
    assign env_out   = env_q;
    assign active    = (state_q != S_IDLE);

endmodule

// File: doc/logs_envelope_dac.md
Name: logs_envelope_dac

Overview:
- Downstream output stage for the logistic-map sonifier.
- Consumes the N raw square-wave oscillator lines, applies a gate-driven attack/decay/sustain/release amplitude envelope, and emits 1-bit first-order sigma-delta audio for the output pin.
- Replaces plain PWM mixing wherever shaped note volume is needed.

Parameters:
- N, 4: number of oscillator inputs.
- ENV_BITS, 8: envelope register width E; MAX = 2^E-1.
- TICK_DIV, 4096: clocks per envelope step, at least 1.
- SUSTAIN, 128: sustain level, 0..MAX.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- audio_in, input, N: oscillator square waves.
- gate, input, 1: note on (high) / note off (low), sampled every clock.
- audio_out, output, 1: registered sigma-delta audio.
- env_out, output, ENV_BITS: current envelope level, registered.
- active, output, 1: high whenever state is not IDLE.

Behaviour:
- Width K = $clog2(N+1).
- Reset values: state IDLE, env 0, prescaler 0, sum_q 0, acc 0, audio_out 0. Therefore env_out = 0 and active = 0.
- Reset mid-operation: all of the above take effect on the next edge, whatever the current state.
- Popcount stage: sum_q <= number of ones in audio_in (K bits), registered, 1 clock.
- Prescaler: counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler == TICK_DIV-1), combinational.
  - Runs continuously after reset, independent of the FSM.
  - TICK_DIV = 1 gives a tick every clock.
- FSM states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Evaluated every clock, in this priority order:
  1. Gate events first, with env unchanged in that cycle.
     - gate high in IDLE or RELEASE -> ATTACK. Retrigger continues from the current env; env is not reset.
     - gate low in ATTACK, DECAY or SUSTAIN -> RELEASE.
  2. ATTACK: if env == MAX -> DECAY; else on tick, env + 1.
  3. DECAY: if env <= SUSTAIN -> SUSTAIN; else on tick, env - 1.
  4. SUSTAIN: env held.
  5. RELEASE: if env == 0 -> IDLE; else on tick, env - 1.
  6. IDLE: env held at 0.
- A gate event coinciding with a tick: the transition wins and there is no env step that cycle.
- env never wraps. It saturates at MAX and 0 by construction of the FSM.
- Sample: sample = sum_q * env, unsigned, K+E bits, computed combinationally from registered values.
- Modulator:
  - FULL = N << E, a constant.
  - Since sample <= N*MAX < FULL, the ones-density equals sample / FULL exactly over a period.
  - acc is K+E bits wide; s = acc + sample is K+E+1 bits wide.
  - If s >= FULL: audio_out <= 1 and acc <= s - FULL.
  - Otherwise: audio_out <= 0 and acc <= s.
- Latency from audio_in to audio_out: 2 clocks (popcount register, then modulator register).
- env change to audio_out effect: 1 clock.
- sample = 0 (audio_in all zero, or env = 0) gives audio_out held 0 once acc has drained below FULL. acc < FULL always holds, so output is 0 immediately.

Test Plan:
Bench parameters: N=4, ENV_BITS=4, TICK_DIV=2, SUSTAIN=8, so FULL=64.
1. Reset held 3 clocks, with gate=1 and audio_in=4'b1111:
   - audio_out=0, env_out=0, active=0 throughout.
   - After release of reset, no output until gate is sampled.
2. gate=1 held, audio_in=4'b1111:
   - active rises 1 clock after gate.
   - env_out steps 0->15, one step per 2 clocks (15 ticks).
   - Then DECAY steps 15->8 (7 ticks), then SUSTAIN holds 8.
   - In sustain: sample=32, so exactly 32 ones in any 64-clock window, alternating 1/0.
3. In SUSTAIN at env=8, audio_in=4'b0001:
   - sample=8, exactly 8 ones per 64 clocks.
   - With audio_in=0: audio_out stays 0 from 2 clocks after the change.
4. gate dropped during ATTACK at env=5:
   - RELEASE the next clock with env still 5.
   - env reaches 0 after 5 ticks, then IDLE, active=0, audio_out stays 0.
5. Retrigger in RELEASE at env=3:
   - gate=1 -> ATTACK with env_out still 3.
   - Next tick gives 4; env never drops to 0.
6. Gate fall coinciding with a tick in DECAY at env=12:
   - Enters RELEASE with env 12, not 11.
   - Reset asserted mid-RELEASE -> all outputs 0 on the next clock.
